// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared widths, FSM states and constants (optional feature macro: BRU_PERF_COUNTERS_EN)
`ifndef DataBusBits
`define DataBusBits 64
`endif
`ifndef BruEntryBits
`define BruEntryBits (2 * `DataBusBits)
`endif

package branch_resolve_unit_pkg;
    typedef enum logic {S_RUN, S_FLUSH} bru_state_e;
    localparam int PC_STEP = 4;
endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// pred_queue: prediction FIFO with simultaneous push/pop and a single-cycle clear
module pred_queue #(
    parameter int W = `BruEntryBits,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // entry storage, written at the tail
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    // pointers wrap naturally; clear drops every entry at once
    always_ff @(posedge clk)
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks fetch predictions in EX, updates the predictor and flushes on mispredict (counters built with BRU_PERF_COUNTERS_EN)
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = `DataBusBits,
    parameter int QDEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dec_push,
    input  logic [XLEN-1:0] dec_pc,
    input  logic [XLEN-1:0] dec_pred_pc,
    input  logic            ex_resolve,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            trap_flush,
    output logic            q_full,
    output logic            q_empty,
    output logic            bp_we,
    output logic [XLEN-1:0] bp_pc_update,
    output logic [XLEN-1:0] bp_target_update,
    output logic            bp_taken_update,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            order_err,
    output logic [31:0]     cf_count,
    output logic [31:0]     mispred_count
);
    localparam int EW = 2 * XLEN;
    bru_state_e state;
    logic [EW-1:0] head;
    logic [XLEN-1:0] actual_pc;
    logic qf, qe, resolve, pc_err, mispred, q_clear, q_pop, push_req, drop, q_push;
    // a trap pre-empts resolve; a wrong head or empty queue is treated as a mispredict
    always_comb begin
        resolve = ex_resolve && !trap_flush;
        actual_pc = ex_taken ? ex_target : ex_pc + XLEN'(PC_STEP);
        pc_err = resolve && (qe || head[EW-1:XLEN] != ex_pc);
        mispred = pc_err || (resolve && head[XLEN-1:0] != actual_pc);
        q_clear = trap_flush || mispred;
        q_pop = resolve && !mispred;
        push_req = dec_push && state == S_RUN && !q_clear;
        drop = push_req && qf && !q_pop;
        q_push = push_req && !drop;
    end
    pred_queue #(.W(EW), .DEPTH(QDEPTH)) u_queue (
        .clk(clk),
        .reset(reset),
        .clear(q_clear),
        .push(q_push),
        .pop(q_pop),
        .din({dec_pc, dec_pred_pc}),
        .dout(head),
        .full(qf),
        .empty(qe)
    );
    assign q_full = qf;
    assign q_empty = qe;
    // FSM and registered predictor-update / flush outputs
    always_ff @(posedge clk)
        if (reset) begin
            state <= S_RUN;
            bp_we <= 1'b0;
            bp_pc_update <= '0;
            bp_target_update <= '0;
            bp_taken_update <= 1'b0;
            flush <= 1'b0;
            redirect_pc <= '0;
            order_err <= 1'b0;
        end else begin
            state <= q_clear ? S_FLUSH : S_RUN;
            bp_we <= resolve;
            bp_pc_update <= resolve ? ex_pc : bp_pc_update;
            bp_target_update <= resolve ? ex_target : bp_target_update;
            bp_taken_update <= resolve ? ex_taken : bp_taken_update;
            flush <= mispred;
            redirect_pc <= mispred ? actual_pc : redirect_pc;
            order_err <= order_err || pc_err || drop;
        end
`ifdef BRU_PERF_COUNTERS_EN
    // resolve and mispredict counters, wrapping at 2^32
    always_ff @(posedge clk)
        if (reset) begin
            cf_count <= '0;
            mispred_count <= '0;
        end else begin
            cf_count <= cf_count + 32'(resolve);
            mispred_count <= mispred_count + 32'(mispred);
        end
`else
    assign cf_count = '0;
    assign mispred_count = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: vector table, corner sequences and randomized model check of branch_resolve_unit
module tb_branch_resolve_unit;
    localparam int QD = 4;
`ifdef BRU_PERF_COUNTERS_EN
    localparam logic PERF = 1'b1;
`else
    localparam logic PERF = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset, dec_push, ex_resolve, ex_taken, trap_flush;
    logic [63:0] dec_pc, dec_pred_pc, ex_pc, ex_target;
    logic q_full, q_empty, bp_we, bp_taken_update, flush, order_err;
    logic [63:0] bp_pc_update, bp_target_update, redirect_pc;
    logic [31:0] cf_count, mispred_count;
    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.XLEN(64), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset), .dec_push(dec_push), .dec_pc(dec_pc), .dec_pred_pc(dec_pred_pc),
        .ex_resolve(ex_resolve), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .trap_flush(trap_flush), .q_full(q_full), .q_empty(q_empty), .bp_we(bp_we),
        .bp_pc_update(bp_pc_update), .bp_target_update(bp_target_update),
        .bp_taken_update(bp_taken_update), .flush(flush), .redirect_pc(redirect_pc),
        .order_err(order_err), .cf_count(cf_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, push; logic [63:0] dpc, dpred;
        logic res; logic [63:0] epc; logic tk; logic [63:0] tgt; logic trap;
        logic e_we, e_tk, e_fl; logic [63:0] e_tgt, e_rd; logic e_err, e_empty, e_full;
    } vec_t;
    vec_t tv[$];

    typedef struct { logic [63:0] pc, pred; } ent_t;
    ent_t mq[$];
    logic m_fl, m_err, m_we, m_tk, m_flo;
    logic [63:0] m_pcu, m_tgt, m_rd;
    logic [31:0] m_cf, m_mis;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic p, input logic [63:0] dpc, input logic [63:0] dpred,
                          input logic res, input logic [63:0] epc, input logic tk, input logic [63:0] tgt,
                          input logic tr);
        reset = r; dec_push = p; dec_pc = dpc; dec_pred_pc = dpred;
        ex_resolve = res; ex_pc = epc; ex_taken = tk; ex_target = tgt; trap_flush = tr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference: a queue of in-flight predictions, updated once per cycle from the rules
    task automatic model_step;
        logic [63:0] act;
        logic mis;
        mis = 1'b0;
        m_we = 1'b0;
        m_flo = 1'b0;
        if (reset) begin
            mq.delete();
            {m_fl, m_err, m_tk} = '0;
            {m_pcu, m_tgt, m_rd} = '0;
            m_cf = 0; m_mis = 0;
            return;
        end
        if (trap_flush) begin
            mq.delete();
            m_fl = 1'b1;
            return;
        end
        if (ex_resolve) begin
            act = ex_taken ? ex_target : ex_pc + 64'd4;
            m_we = 1'b1; m_pcu = ex_pc; m_tgt = ex_target; m_tk = ex_taken;
            if (PERF) m_cf++;
            if (mq.size() == 0 || mq[0].pc != ex_pc) begin
                m_err = 1'b1;
                mis = 1'b1;
            end else mis = mq[0].pred != act;
            if (mis) begin
                if (PERF) m_mis++;
                m_flo = 1'b1;
                m_rd = act;
                mq.delete();
            end else void'(mq.pop_front());
        end
        if (dec_push && !m_fl && !mis) begin
            if (mq.size() == QD) m_err = 1'b1;
            else mq.push_back('{dec_pc, dec_pred_pc});
        end
        m_fl = mis;
    endtask

    task automatic check_model(input int c);
        chk($sformatf("c%0d q_empty", c), q_empty, mq.size() == 0);
        chk($sformatf("c%0d q_full", c), q_full, mq.size() == QD);
        chk($sformatf("c%0d bp_we", c), bp_we, m_we);
        chk($sformatf("c%0d flush", c), flush, m_flo);
        chk($sformatf("c%0d order_err", c), order_err, m_err);
        chk($sformatf("c%0d cf_count", c), cf_count, m_cf);
        chk($sformatf("c%0d mispred_count", c), mispred_count, m_mis);
        if (m_we) begin
            chk($sformatf("c%0d bp_pc", c), bp_pc_update, m_pcu);
            chk($sformatf("c%0d bp_target", c), bp_target_update, m_tgt);
            chk($sformatf("c%0d bp_taken", c), bp_taken_update, m_tk);
        end
        if (m_flo) chk($sformatf("c%0d redirect", c), redirect_pc, m_rd);
    endtask

    initial begin
        logic [63:0] pc;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset q_empty", q_empty, 1);
        chk("reset q_full", q_full, 0);
        chk("reset bp_we", bp_we, 0);
        chk("reset bp_pc", bp_pc_update, 0);
        chk("reset bp_target", bp_target_update, 0);
        chk("reset bp_taken", bp_taken_update, 0);
        chk("reset flush", flush, 0);
        chk("reset redirect", redirect_pc, 0);
        chk("reset order_err", order_err, 0);
        chk("reset cf_count", cf_count, 0);
        chk("reset mispred_count", mispred_count, 0);

        // rst push dpc dpred res epc tk tgt trap | we tk fl tgt rd err empty full
        tv.push_back('{0, 1, 'h100, 'h104, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 0, 0, 1, 'h100, 0, 0, 0,      1, 0, 0, 0, 0, 0, 1, 0});
        tv.push_back('{0, 1, 'h200, 'h204, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 0, 0, 1, 'h200, 1, 'h400, 0,  1, 1, 1, 'h400, 'h400, 0, 1, 0});
        tv.push_back('{0, 1, 'h500, 'h504, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0});
        tv.push_back('{0, 1, 'h600, 'h604, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 1, 'h610, 'h614, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 1, 'h620, 'h624, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 1, 'h630, 'h634, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1});
        tv.push_back('{0, 1, 'h640, 'h644, 1, 'h600, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1});
        tv.push_back('{0, 1, 'h650, 'h654, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 1});
        tv.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 1, 0});
        tv.push_back('{0, 1, 'h700, 'h704, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 1, 'h710, 'h714, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 1, 'h720, 'h724, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 0, 0, 1, 'h700, 0, 0, 1,      0, 0, 0, 0, 0, 0, 1, 0});
        tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 1, 0});
        tv.push_back('{0, 0, 0, 0, 1, 'h300, 0, 0, 0,      1, 0, 1, 0, 'h304, 1, 1, 0});
        foreach (tv[i]) begin
            set_in(tv[i].rst, tv[i].push, tv[i].dpc, tv[i].dpred, tv[i].res, tv[i].epc, tv[i].tk, tv[i].tgt, tv[i].trap);
            tick();
            chk($sformatf("v%0d bp_we", i), bp_we, tv[i].e_we);
            chk($sformatf("v%0d flush", i), flush, tv[i].e_fl);
            chk($sformatf("v%0d order_err", i), order_err, tv[i].e_err);
            chk($sformatf("v%0d q_empty", i), q_empty, tv[i].e_empty);
            chk($sformatf("v%0d q_full", i), q_full, tv[i].e_full);
            if (tv[i].e_we) begin
                chk($sformatf("v%0d bp_taken", i), bp_taken_update, tv[i].e_tk);
                chk($sformatf("v%0d bp_target", i), bp_target_update, tv[i].e_tgt);
                chk($sformatf("v%0d bp_pc", i), bp_pc_update, tv[i].epc);
            end
            if (tv[i].e_fl) chk($sformatf("v%0d redirect", i), redirect_pc, tv[i].e_rd);
        end

        // reset arriving with a pending mispredict discards the pulse
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 'h800, 'h804, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 1, 'h800, 1, 'h900, 0);
        tick();
        chk("rstpend flush", flush, 0);
        chk("rstpend bp_we", bp_we, 0);
        chk("rstpend q_empty", q_empty, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rstpend2 flush", flush, 0);
        chk("rstpend2 bp_we", bp_we, 0);

        // five resolves, the last two mispredicted
        for (int k = 0; k < 5; k++) begin
            pc = 64'h1000 + 64'(k) * 64'h20;
            set_in(0, 1, pc, pc + 4, 0, 0, 0, 0, 0);
            tick();
            set_in(0, 0, 0, 0, 1, pc, k >= 3, pc + 64'h40, 0);
            tick();
            chk($sformatf("perf%0d flush", k), flush, k >= 3);
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        chk("perf cf_count", cf_count, PERF ? 5 : 0);
        chk("perf mispred_count", mispred_count, PERF ? 2 : 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("perf reset cf_count", cf_count, 0);
        chk("perf reset mispred_count", mispred_count, 0);

        // randomized traffic against the queue model
        model_step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic [63:0] dp, hp;
            reset = $urandom_range(99) == 0;
            trap_flush = $urandom_range(99) < 3;
            dec_push = $urandom_range(1);
            dp = $urandom_range(7) == 0 ? 64'hFFFF_FFFF_FFFF_FFFC : {32'h0, $urandom} & ~64'h3;
            dec_pc = dp;
            dec_pred_pc = $urandom_range(1) ? dp + 64'd4 : {48'h0, 16'($urandom)} & ~64'h3;
            ex_resolve = $urandom_range(1);
            hp = mq.size() > 0 ? mq[0].pred : 64'h0;
            ex_pc = (mq.size() > 0 && $urandom_range(9) != 0) ? mq[0].pc : {32'h0, $urandom} & ~64'h3;
            ex_taken = $urandom_range(1);
            ex_target = $urandom_range(4) < 3 ? hp : {48'h0, 16'($urandom)};
            model_step();
            tick();
            check_model(c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
